// File: rtl/return_stack_ckpt_ctrl.sv
// Speculative return-address stack with per-branch checkpoints.
// Predicted calls push and predicted returns pop a circular stack. Each
// checkpoint records {index, fill count, TOS entry}, so a mispredict can
// rewind the pointer and repair the one TOS slot a later push may have
// clobbered. All updates land on the clock edge; outputs reflect current state.
module return_stack_ckpt_ctrl #(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_CKPT    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        IN_push,
  input  logic [30:0]                 IN_pushData,
  input  logic                        IN_pop,
  input  logic                        IN_ckptValid,
  input  logic [$clog2(NUM_CKPT)-1:0] IN_ckptTag,
  input  logic                        IN_recValid,
  input  logic [$clog2(NUM_CKPT)-1:0] IN_recTag,
  input  logic                        IN_recPush,
  input  logic [30:0]                 IN_recPushData,
  input  logic                        IN_recPop,
  output logic                        OUT_valid,
  output logic [30:0]                 OUT_data
);

  localparam int IW = $clog2(NUM_ENTRIES);
  localparam int FW = $clog2(NUM_ENTRIES + 1);
  localparam logic [FW-1:0] FULL = FW'(NUM_ENTRIES);

  logic [IW-1:0] index_reg, index_next;
  logic [FW-1:0] filled_reg, filled_next;
  logic [30:0]   stack_reg [NUM_ENTRIES];

  logic [IW-1:0] ckpt_index_reg  [NUM_CKPT];
  logic [FW-1:0] ckpt_filled_reg [NUM_CKPT];
  logic [30:0]   ckpt_tos_reg    [NUM_CKPT];

  logic [IW-1:0] tos_ptr;
  logic [IW-1:0] rec_index;
  logic [FW-1:0] rec_filled;
  logic [30:0]   rec_tos;
  logic          ckpt_we;

  // Two stack write ports: port A is the normal push / TOS replace / TOS
  // repair, port B is the push carried by a recovering call. During recovery
  // they address ci-1 and ci, which never collide for NUM_ENTRIES >= 2.
  logic          wr_a_en;
  logic [IW-1:0] wr_a_addr;
  logic [30:0]   wr_a_data;
  logic          wr_b_en;
  logic [IW-1:0] wr_b_addr;
  logic [30:0]   wr_b_data;

  assign tos_ptr    = index_reg - IW'(1);
  assign rec_index  = ckpt_index_reg[IN_recTag];
  assign rec_filled = ckpt_filled_reg[IN_recTag];
  assign rec_tos    = ckpt_tos_reg[IN_recTag];
  assign ckpt_we    = IN_ckptValid && !IN_recValid;

  assign OUT_valid = (filled_reg != '0);
  assign OUT_data  = stack_reg[tos_ptr];

  // Next pointer/fill count and stack write requests; recovery wins over all.
  always_comb begin
    index_next  = index_reg;
    filled_next = filled_reg;
    wr_a_en     = 1'b0;
    wr_a_addr   = index_reg;
    wr_a_data   = IN_pushData;
    wr_b_en     = 1'b0;
    wr_b_addr   = rec_index;
    wr_b_data   = IN_recPushData;

    if (IN_recValid) begin
      wr_a_en   = 1'b1;
      wr_a_addr = rec_index - IW'(1);
      wr_a_data = rec_tos;
      if (IN_recPush) begin
        wr_b_en     = 1'b1;
        index_next  = rec_index + IW'(1);
        filled_next = (rec_filled == FULL) ? FULL : rec_filled + FW'(1);
      end else if (IN_recPop && rec_filled != '0) begin
        index_next  = rec_index - IW'(1);
        filled_next = rec_filled - FW'(1);
      end else begin
        index_next  = rec_index;
        filled_next = rec_filled;
      end
    end else if (IN_push && IN_pop && filled_reg != '0) begin
      // Pop-then-push collapses into replacing the current TOS.
      wr_a_en   = 1'b1;
      wr_a_addr = tos_ptr;
    end else if (IN_push) begin
      // Includes push+pop on an empty stack, where the pop has nothing to do.
      wr_a_en     = 1'b1;
      index_next  = index_reg + IW'(1);
      filled_next = (filled_reg == FULL) ? FULL : filled_reg + FW'(1);
    end else if (IN_pop && filled_reg != '0) begin
      index_next  = index_reg - IW'(1);
      filled_next = filled_reg - FW'(1);
    end
  end

  // Stack pointer and fill count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_reg  <= '0;
      filled_reg <= '0;
    end else begin
      index_reg  <= index_next;
      filled_reg <= filled_next;
    end
  end

  // Stack storage; cleared on reset so a restored empty stack reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        stack_reg[i] <= '0;
      end
    end else begin
      if (wr_a_en) stack_reg[wr_a_addr] <= wr_a_data;
      if (wr_b_en) stack_reg[wr_b_addr] <= wr_b_data;
    end
  end

  // Checkpoint slots capture pre-update state; recovery cycles take none.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        ckpt_index_reg[i]  <= '0;
        ckpt_filled_reg[i] <= '0;
        ckpt_tos_reg[i]    <= '0;
      end
    end else if (ckpt_we) begin
      ckpt_index_reg[IN_ckptTag]  <= index_reg;
      ckpt_filled_reg[IN_ckptTag] <= filled_reg;
      ckpt_tos_reg[IN_ckptTag]    <= stack_reg[tos_ptr];
    end
  end

  // A mispredicted instruction cannot be both a call and a return.
  always @(posedge clk) begin
    if (!rst && IN_recValid) begin
      assert (!(IN_recPush && IN_recPop));
    end
  end

endmodule

// File: tb/tb_return_stack_ckpt_ctrl.sv
// Directed, table-driven bench for return_stack_ckpt_ctrl.
module tb_return_stack_ckpt_ctrl;

  logic        clk;
  logic        rst;
  logic        push;
  logic [30:0] push_data;
  logic        pop;
  logic        ckpt_valid;
  logic [1:0]  ckpt_tag;
  logic        rec_valid;
  logic [1:0]  rec_tag;
  logic        rec_push;
  logic [30:0] rec_push_data;
  logic        rec_pop;
  logic        out_valid;
  logic [30:0] out_data;

  int checks = 0;
  int errors = 0;

  return_stack_ckpt_ctrl #(.NUM_ENTRIES(8), .NUM_CKPT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .IN_push       (push),
    .IN_pushData   (push_data),
    .IN_pop        (pop),
    .IN_ckptValid  (ckpt_valid),
    .IN_ckptTag    (ckpt_tag),
    .IN_recValid   (rec_valid),
    .IN_recTag     (rec_tag),
    .IN_recPush    (rec_push),
    .IN_recPushData(rec_push_data),
    .IN_recPop     (rec_pop),
    .OUT_valid     (out_valid),
    .OUT_data      (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          rst;
    bit          push;
    logic [30:0] pd;
    bit          pop;
    bit          ck;
    logic [1:0]  ckt;
    bit          rv;
    logic [1:0]  rt;
    bit          rpush;
    logic [30:0] rpd;
    bit          rpop;
    bit          ev;
    logic [30:0] ed;
  } vec_t;

  vec_t vecs [100];
  int   n_vec = 0;

  task automatic add(input string name, input bit r, input bit pu, input logic [30:0] pd,
                     input bit po, input bit ck, input logic [1:0] ckt, input bit rv,
                     input logic [1:0] rt, input bit rpu, input logic [30:0] rpd,
                     input bit rpo, input bit ev, input logic [30:0] ed);
    vecs[n_vec] = '{name, r, pu, pd, po, ck, ckt, rv, rt, rpu, rpd, rpo, ev, ed};
    n_vec++;
  endtask

  task automatic v_rst(input string name);
    add(name, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic v_push(input string name, input logic [30:0] d, input bit ev, input logic [30:0] ed);
    add(name, 0, 1, d, 0, 0, 0, 0, 0, 0, 0, 0, ev, ed);
  endtask
  task automatic v_pop(input string name, input bit ev, input logic [30:0] ed);
    add(name, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, ev, ed);
  endtask
  task automatic v_pp(input string name, input logic [30:0] d, input bit ev, input logic [30:0] ed);
    add(name, 0, 1, d, 1, 0, 0, 0, 0, 0, 0, 0, ev, ed);
  endtask

  task automatic check(input string name, input bit ev, input logic [30:0] ed);
    checks++;
    if (out_valid !== ev || out_data !== ed) begin
      errors++;
      $display("FAIL %s: got valid=%0d data=%h, expected valid=%0d data=%h",
               name, out_valid, out_data, ev, ed);
    end else begin
      $display("ok   %s: valid=%0d data=%h", name, out_valid, out_data);
    end
  endtask

  task automatic idle_inputs();
    push = 0; push_data = '0; pop = 0; ckpt_valid = 0; ckpt_tag = '0;
    rec_valid = 0; rec_tag = '0; rec_push = 0; rec_push_data = '0; rec_pop = 0;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; push = v.push; push_data = v.pd; pop = v.pop;
    ckpt_valid = v.ck; ckpt_tag = v.ckt; rec_valid = v.rv; rec_tag = v.rt;
    rec_push = v.rpush; rec_push_data = v.rpd; rec_pop = v.rpop;
    @(posedge clk);
    #1;
    check(v.name, v.ev, v.ed);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // Basic push/pop and pop-when-empty.
    v_push("p100", 31'h100, 1, 31'h100);
    v_push("p200", 31'h200, 1, 31'h200);
    v_push("p300", 31'h300, 1, 31'h300);
    v_pop("pop_to_200", 1, 31'h200);
    v_pop("pop_to_100", 1, 31'h100);
    v_pop("pop_to_empty", 0, 31'h0);
    v_pop("pop_empty_ignored", 0, 31'h0);
    v_push("p55_after_empty", 31'h55, 1, 31'h55);
    v_pop("pop55", 0, 31'h0);

    // Overflow: ten pushes into eight entries, then drain.
    v_rst("rst_overflow");
    for (int k = 1; k <= 10; k++) v_push("fill", 31'(k), 1, 31'(k));
    for (int i = 1; i <= 7; i++) v_pop("drain", 1, 31'(10 - i));
    v_pop("drain_last", 0, 31'd10);
    v_pop("drain_extra", 0, 31'd10);

    // Checkpoint then recover with no rec op, repairing the clobbered TOS.
    v_rst("rst_ck2");
    v_push("ck2_pA", 31'hA, 1, 31'hA);
    v_push("ck2_pB", 31'hB, 1, 31'hB);
    add("ck2_take", 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 1, 31'hB);
    v_pop("ck2_pop", 1, 31'hA);
    v_push("ck2_pC", 31'hC, 1, 31'hC);
    add("ck2_recover", 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 31'hB);
    v_pop("ck2_pop_A", 1, 31'hA);
    v_pop("ck2_pop_empty", 0, 31'h0);

    // Recover with a push, then a checkpoint taken alongside a push recovered with a pop.
    v_rst("rst_ck1");
    v_push("ck1_pA", 31'hA, 1, 31'hA);
    add("ck1_take", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 31'hA);
    v_push("ck1_pB", 31'hB, 1, 31'hB);
    add("ck1_rec_push", 0, 0, 0, 0, 0, 0, 1, 1, 1, 31'hD, 0, 1, 31'hD);
    v_pop("ck1_pop_A", 1, 31'hA);
    v_pop("ck1_pop_empty", 0, 31'h0);
    v_push("ck3_pE", 31'hE, 1, 31'hE);
    v_push("ck3_pF", 31'hF, 1, 31'hF);
    add("ck3_take_push_G", 0, 1, 31'h1F, 0, 1, 3, 0, 0, 0, 0, 0, 1, 31'h1F);
    add("ck3_rec_pop", 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 1, 1, 31'hE);
    v_pop("ck3_pop_empty", 0, 31'h0);

    // Simultaneous push+pop on non-empty and empty stacks.
    v_rst("rst_pp");
    v_push("pp_p5", 31'h5, 1, 31'h5);
    v_pp("pp_replace", 31'h7, 1, 31'h7);
    v_pop("pp_one_entry", 0, 31'h0);
    v_pp("pp_empty", 31'h7, 1, 31'h7);
    v_pop("pp_empty_one_entry", 0, 31'h0);

    // Recovery from a never-written slot ignores push and checkpoint.
    v_rst("rst_rec0");
    v_push("r0_p1", 31'h1, 1, 31'h1);
    v_push("r0_p2", 31'h2, 1, 31'h2);
    add("r0_rec_with_push_ck", 0, 1, 31'h9, 0, 1, 0, 1, 0, 0, 0, 0, 0, 31'h0);
    v_push("r0_p3", 31'h3, 1, 31'h3);
    add("r0_rec_again", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 31'h0);

    // Hold reset for two edges and check the reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_state", 0, 31'h0);

    for (int i = 0; i < n_vec; i++) apply(vecs[i]);

    // Asynchronous reset mid-cycle clears the stack and checkpoints at once.
    @(negedge clk);
    idle_inputs();
    rst = 0;
    push = 1; push_data = 31'h44;
    @(posedge clk); #1;
    check("async_p44", 1, 31'h44);
    @(negedge clk);
    push = 0; ckpt_valid = 1; ckpt_tag = 2'd1;
    @(posedge clk); #1;
    check("async_ck1", 1, 31'h44);
    @(negedge clk);
    idle_inputs();
    push = 1; push_data = 31'h66;
    #2;
    rst = 1;
    #1;
    check("async_rst_immediate", 0, 31'h0);
    @(posedge clk); #1;
    check("async_rst_held", 0, 31'h0);
    @(negedge clk);
    idle_inputs();
    rst = 0;
    rec_valid = 1; rec_tag = 2'd1;
    @(posedge clk); #1;
    check("async_ckpt_cleared", 0, 31'h0);
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
